// File: rtl/chunked_addsub_unit.sv
// Multi-cycle two's-complement add/subtract unit: processes WIDTH bits CHUNK bits per
// cycle, LSB chunk first, with a registered ripple carry and valid/ready on both sides.
module chunked_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             borrow,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] result_d;
    logic             in_ready_d, out_valid_d;
    logic             carry_d, borrow_d, overflow_d, zero_d, negative_d;
    logic [CHUNK:0]   sum_c;
    int unsigned      base_c;

    assign base_c = 32'(idx_q) * CHUNK;

    // State register and all datapath/output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            sub_q     <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            sub_q     <= sub_d;
            result    <= result_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            carry     <= carry_d;
            borrow    <= borrow_d;
            overflow  <= overflow_d;
            zero      <= zero_d;
            negative  <= negative_d;
        end
    end

    // Next-state, chunk adder and flag computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sub_d       = sub_q;
        result_d    = result;
        out_valid_d = out_valid;
        carry_d     = carry;
        borrow_d    = borrow;
        overflow_d  = overflow;
        zero_d      = zero;
        negative_d  = negative;

        sum_c = {1'b0, a_q[base_c +: CHUNK]} + {1'b0, b_q[base_c +: CHUNK]} + (CHUNK + 1)'(c_q);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    // Subtraction runs as A + ~B + 1 with the +1 as carry-in
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub;
                    sub_d   = sub;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                result_d[base_c +: CHUNK] = sum_c[CHUNK-1:0];
                c_d = sum_c[CHUNK];
                if (idx_q == LAST_IDX) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    carry_d     = sum_c[CHUNK];
                    borrow_d    = sub_q & ~sum_c[CHUNK];
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sum_c[CHUNK-1] != a_q[WIDTH-1]);
                    zero_d      = ~|result_d;
                    negative_d  = sum_c[CHUNK-1];
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_chunked_addsub_unit.sv
// Scoreboard bench: directed hand-computed vectors on a 16/4 unit plus model-checked
// random traffic on four (WIDTH, CHUNK) configurations.
`timescale 1ns/1ps
module tb_chunked_addsub_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        bw;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic bw,
                                input logic ov, input logic z, input logic n);
        exp_t e;
        e.res = r; e.c = c; e.bw = bw; e.ov = ov; e.z = z; e.n = n;
        return e;
    endfunction

    // ---------------- directed unit, default parameters ----------------
    localparam int unsigned DW = 16;
    localparam int unsigned DC = 4;
    localparam int unsigned DN = DW / DC;

    logic          d_rst_n, d_in_valid, d_in_ready, d_sub, d_out_valid, d_out_ready;
    logic          d_carry, d_borrow, d_overflow, d_zero, d_negative;
    logic [DW-1:0] d_a, d_b, d_result;
    exp_t          d_q[$];

    chunked_addsub_unit #(.WIDTH(DW), .CHUNK(DC)) u_dir (
        .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .sub(d_sub), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .carry(d_carry), .borrow(d_borrow), .overflow(d_overflow),
        .zero(d_zero), .negative(d_negative)
    );

    always @(negedge clk) begin
        if (d_rst_n && d_out_valid && d_out_ready) begin
            if (d_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dir_unexpected_output actual=result_%h required=no_output", d_result);
            end else begin
                exp_t e;
                e = d_q.pop_front();
                chk("dir_scoreboard",
                    40'({32'(d_result), d_carry, d_borrow, d_overflow, d_zero, d_negative}),
                    40'(e));
            end
        end
    end

    task automatic d_issue(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s, input exp_t e);
        bit acc;
        acc = 1'b0;
        d_a = x; d_b = y; d_sub = s; d_in_valid = 1'b1;
        d_q.push_back(e);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = d_in_ready;
            @(posedge clk);
            #1;
        end
        d_in_valid = 1'b0;
        if (!acc) fail_now("dir_accept");
    endtask

    task automatic d_drain();
        for (int i = 0; i < 100 && d_q.size() != 0; i++) @(posedge clk);
        #1;
        if (d_q.size() != 0) fail_now("dir_drain");
    endtask

    task automatic d_run(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s, input exp_t e);
        d_issue(x, y, s, e);
        d_drain();
    endtask

    function automatic logic [39:0] d_flags();
        return 40'({d_carry, d_borrow, d_overflow, d_zero, d_negative});
    endfunction

    initial begin
        d_rst_n = 1'b0; d_in_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset_out_valid", 40'(d_out_valid), 40'(0));
        d_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 40'(d_in_ready), 40'(1));
        chk("reset_out_valid", 40'(d_out_valid), 40'(0));
        chk("reset_result", 40'(d_result), 40'(0));
        chk("reset_flags", d_flags(), 40'(0));

        // Idle with in_valid low: nothing starts
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", 40'(d_in_ready), 40'(1));
        chk("idle_out_valid", 40'(d_out_valid), 40'(0));

        // Latency: out_valid exactly NCHUNK edges after accept
        d_out_ready = 1'b0;
        d_issue(16'h0002, 16'h0001, 1'b1, mk(32'h0001, 1, 0, 0, 0, 0));
        repeat (DN - 1) @(posedge clk);
        #1;
        chk("latency_early", 40'(d_out_valid), 40'(0));
        @(posedge clk); #1;
        chk("latency_valid", 40'(d_out_valid), 40'(1));
        d_out_ready = 1'b1;
        d_drain();

        d_run(16'h0001, 16'h0002, 1'b1, mk(32'hFFFF, 0, 1, 0, 0, 1));
        d_run(16'h7FFF, 16'h0001, 1'b0, mk(32'h8000, 0, 0, 1, 0, 1));
        d_run(16'h8000, 16'h0001, 1'b1, mk(32'h7FFF, 1, 0, 1, 0, 0));
        d_run(16'h1234, 16'h1234, 1'b1, mk(32'h0000, 1, 0, 0, 1, 0));
        d_run(16'hFFFF, 16'h0001, 1'b0, mk(32'h0000, 1, 0, 0, 1, 0));
        d_run(16'h8000, 16'h8000, 1'b0, mk(32'h0000, 1, 0, 1, 1, 0));
        d_run(16'h0000, 16'h0000, 1'b1, mk(32'h0000, 1, 0, 0, 1, 0));

        // Backpressure, busy in_valid and operand changes after acceptance
        d_out_ready = 1'b0;
        d_issue(16'h00F0, 16'h0F0F, 1'b0, mk(32'h0FFF, 0, 0, 0, 0, 0));
        d_a = 16'h1111; d_b = 16'h2222; d_sub = 1'b0; d_in_valid = 1'b1;
        d_q.push_back(mk(32'h3333, 0, 0, 0, 0, 0));
        repeat (DN) begin
            @(posedge clk); #1;
            chk("busy_in_ready", 40'(d_in_ready), 40'(0));
        end
        repeat (10) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 40'(d_out_valid), 40'(1));
            chk("hold_result", 40'(d_result), 40'(16'h0FFF));
            chk("hold_flags", d_flags(), 40'(0));
            chk("hold_in_ready", 40'(d_in_ready), 40'(0));
        end
        d_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 40'(d_out_valid), 40'(0));
        chk("release_in_ready", 40'(d_in_ready), 40'(1));
        @(posedge clk); #1;
        chk("held_op_accepted", 40'(d_in_ready), 40'(0));
        d_in_valid = 1'b0;
        d_drain();

        // Asynchronous reset at CALC index 2 aborts the operation
        d_issue(16'h5555, 16'h1111, 1'b0, mk(32'h6666, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        d_rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 40'(d_out_valid), 40'(0));
        chk("abort_result", 40'(d_result), 40'(0));
        chk("abort_flags", d_flags(), 40'(0));
        d_q.delete();
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 40'(d_out_valid), 40'(0));
        end
        d_rst_n = 1'b1;
        @(posedge clk); #1;
        d_run(16'h5555, 16'h1111, 1'b0, mk(32'h6666, 0, 0, 0, 0, 0));

        for (int i = 0; i < 60000 && done_cnt < 4; i++) @(posedge clk);
        if (done_cnt < 4) fail_now("random_phase_done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- random traffic against an arithmetic model ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int unsigned W = (g == 0) ? 16 : (g == 1) ? 32 : 8;
        localparam int unsigned C = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 8 : 1;

        logic         r_rst_n, in_valid, in_ready, sub, out_valid, out_ready;
        logic         carry, borrow, overflow, zero, negative;
        logic [W-1:0] a, b, result;
        exp_t         q[$];

        chunked_addsub_unit #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst_n(r_rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
            .result(result), .carry(carry), .borrow(borrow), .overflow(overflow),
            .zero(zero), .negative(negative)
        );

        function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
            longint m  = longint'(1) << W;
            longint ux = longint'(x);
            longint uy = longint'(y);
            longint sx = (ux >= m / 2) ? ux - m : ux;
            longint sy = (uy >= m / 2) ? uy - m : uy;
            longint ur;
            longint sr;
            exp_t   e;
            if (s) begin
                ur   = ux - uy;
                sr   = sx - sy;
                e.c  = (ux >= uy);
                e.bw = (ux < uy);
            end else begin
                ur   = ux + uy;
                sr   = sx + sy;
                e.c  = (ur >= m);
                e.bw = 1'b0;
            end
            e.ov  = (sr >= m / 2) || (sr < -(m / 2));
            e.res = 32'(ur & (m - 1));
            e.z   = (e.res == 32'd0);
            e.n   = e.res[W-1];
            return e;
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            case ($urandom_range(7))
                0: v = '0;
                1: v = '1;
                2: v = {1'b1, {(W - 1){1'b0}}};
                3: v = {1'b0, {(W - 1){1'b1}}};
                default: v = W'({$urandom, $urandom});
            endcase
            return v;
        endfunction

        always @(negedge clk) begin
            if (r_rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd%0d_unexpected_output actual=result_%h required=no_output", g, result);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("rnd%0d_scoreboard", g),
                        40'({32'(result), carry, borrow, overflow, zero, negative}), 40'(e));
                end
            end
        end

        initial begin
            out_ready = 1'b1;
            forever begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(3) != 0);
            end
        end

        initial begin
            r_rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            r_rst_n = 1'b1;
            for (int n = 0; n < 1000; n++) begin
                bit acc;
                acc = 1'b0;
                a = pick(); b = pick(); sub = 1'($urandom_range(1));
                in_valid = 1'b1;
                q.push_back(model(a, b, sub));
                for (int i = 0; i < 200 && !acc; i++) begin
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
                if (!acc) fail_now($sformatf("rnd%0d_accept", g));
                a = pick(); b = pick(); sub = 1'($urandom_range(1));
                repeat ($urandom_range(2)) @(posedge clk);
                #1;
            end
            for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
            if (q.size() != 0) fail_now($sformatf("rnd%0d_drain", g));
            done_cnt++;
        end
    end

endmodule
